// File: rtl/vram_port_arbiter.sv
// VRAM port arbiter: fixed-schedule display fetch with strict priority, host req/ack in free slots.
// Optional build macro VRAM_ARB_STATS_EN adds the stall_cnt output.
module vram_port_arbiter #(
  parameter int H_TOTAL       = 800,
  parameter int V_TOTAL       = 525,
  parameter int H_ACTIVE      = 640,
  parameter int V_ACTIVE      = 480,
  parameter int WORDS_PER_ROW = 40,
  parameter int ROW_SHIFT     = 4,
  parameter int VRAM_WORDS    = 1200,
  parameter int ADDR_W        = 11
) (
  input  logic              pixel_clk,
  input  logic              arstn,
  input  logic [9:0]        drawX,
  input  logic [9:0]        drawY,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [31:0]       host_wdata,
  input  logic [3:0]        host_wstrb,
  output logic              host_ack,
  output logic [31:0]       host_rdata,
  output logic              host_err,
  output logic [31:0]       disp_word,
`ifdef VRAM_ARB_STATS_EN
  output logic [15:0]       stall_cnt,
`endif
  output logic              ram_en,
  output logic [3:0]        ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata
);

  typedef enum logic [1:0] {H_IDLE, H_RD, H_ACK} host_state_t;
  typedef enum logic [1:0] {OWN_NONE, OWN_DISP, OWN_HOST} owner_t;

  localparam logic [9:0]        X_COL_LIMIT = 10'(H_ACTIVE - 3);
  localparam logic [9:0]        X_ROW_FETCH = 10'(H_TOTAL - 3);
  localparam logic [9:0]        X_LAST      = 10'(H_TOTAL - 1);
  localparam logic [9:0]        Y_LAST      = 10'(V_TOTAL - 1);
  localparam logic [9:0]        Y_ACTIVE    = 10'(V_ACTIVE);
  localparam logic [ADDR_W-1:0] ADDR_LIMIT  = ADDR_W'(VRAM_WORDS);

  host_state_t       state;
  owner_t            owner;
  logic [31:0]       disp_buf;
  logic              err_pend;
  logic [9:0]        next_y;
  logic              slot_col;
  logic              slot_row;
  logic              fetch_slot;
  logic [ADDR_W-1:0] fetch_addr;
  logic              can_issue;
  logic              issue;
  logic              in_range;

  // Fetch one column word 3 pixels ahead, and the first word of the next line during h-blank.
  assign next_y     = (drawY == Y_LAST) ? 10'd0 : drawY + 10'd1;
  assign slot_col   = (drawY < Y_ACTIVE) && (drawX[3:0] == 4'd13) && (drawX < X_COL_LIMIT);
  assign slot_row   = (drawX == X_ROW_FETCH) && (next_y < Y_ACTIVE);
  assign fetch_slot = slot_col || slot_row;

  always_comb begin
    if (slot_row)
      fetch_addr = ADDR_W'((32'(next_y) >> ROW_SHIFT) * 32'(WORDS_PER_ROW));
    else
      fetch_addr = ADDR_W'((32'(drawY) >> ROW_SHIFT) * 32'(WORDS_PER_ROW)
                           + ((32'(drawX) + 32'd3) >> 4));
  end

  // No issue during the ack cycle, so a held request starts a fresh transaction afterwards.
  assign can_issue = (state == H_IDLE) && host_req && !host_ack;
  assign issue     = can_issue && !fetch_slot;
  assign in_range  = host_addr < ADDR_LIMIT;

  always_comb begin
    ram_en    = 1'b0;
    ram_we    = 4'd0;
    ram_addr  = '0;
    ram_wdata = 32'd0;
    if (arstn) begin
      if (fetch_slot) begin
        ram_en   = 1'b1;
        ram_addr = fetch_addr;
      end else if (issue && in_range) begin
        ram_en   = 1'b1;
        ram_addr = host_addr;
        if (host_we) begin
          ram_we    = host_wstrb;
          ram_wdata = host_wdata;
        end
      end
    end
  end

  // The owner tag remembers who issued last cycle's read so the two data paths never mix.
  always_ff @(posedge pixel_clk) begin
    if (!arstn) begin
      state      <= H_IDLE;
      owner      <= OWN_NONE;
      disp_buf   <= 32'd0;
      disp_word  <= 32'd0;
      host_ack   <= 1'b0;
      host_err   <= 1'b0;
      host_rdata <= 32'd0;
      err_pend   <= 1'b0;
    end else begin
      host_ack <= 1'b0;
      host_err <= 1'b0;

      if (fetch_slot)
        owner <= OWN_DISP;
      else if (issue && in_range && !host_we)
        owner <= OWN_HOST;
      else
        owner <= OWN_NONE;

      if (owner == OWN_DISP)
        disp_buf <= ram_rdata;
      if ((drawX[3:0] == 4'hF) || (drawX == X_LAST))
        disp_word <= disp_buf;

      case (state)
        H_IDLE: begin
          if (issue) begin
            if (!in_range) begin
              err_pend   <= 1'b1;
              host_rdata <= 32'd0;
              state      <= H_ACK;
            end else if (host_we) begin
              err_pend <= 1'b0;
              state    <= H_ACK;
            end else begin
              err_pend <= 1'b0;
              state    <= H_RD;
            end
          end
        end
        H_RD: begin
          host_rdata <= ram_rdata;
          state      <= H_ACK;
        end
        H_ACK: begin
          host_ack <= 1'b1;
          host_err <= err_pend;
          state    <= H_IDLE;
        end
        default: state <= H_IDLE;
      endcase
    end
  end

`ifdef VRAM_ARB_STATS_EN
  // Counts host cycles lost to fetch collisions, restarting at the top of each frame.
  always_ff @(posedge pixel_clk) begin
    if (!arstn || ((drawX == 10'd0) && (drawY == 10'd0)))
      stall_cnt <= 16'd0;
    else if (can_issue && fetch_slot && (stall_cnt != 16'hFFFF))
      stall_cnt <= stall_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_vram_port_arbiter.sv
// Directed self-checking bench for vram_port_arbiter with a byte-enabled 1-cycle-latency RAM model.
module tb_vram_port_arbiter;

  logic        pixel_clk = 1'b0;
  logic        arstn;
  logic [9:0]  drawX;
  logic [9:0]  drawY;
  logic        host_req;
  logic        host_we;
  logic [10:0] host_addr;
  logic [31:0] host_wdata;
  logic [3:0]  host_wstrb;
  logic        host_ack;
  logic [31:0] host_rdata;
  logic        host_err;
  logic [31:0] disp_word;
  logic        ram_en;
  logic [3:0]  ram_we;
  logic [10:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;
`ifdef VRAM_ARB_STATS_EN
  logic [15:0] stall_cnt;
  logic [15:0] stall_before;
`endif

  logic        fill_identity;
  logic        poke_en;
  logic [10:0] poke_addr;
  logic [31:0] poke_data;
  logic [31:0] mem [0:2047];

  int checkCount = 0;
  int passCount  = 0;
  int failCount  = 0;

  vram_port_arbiter dut (
    .pixel_clk (pixel_clk),
    .arstn     (arstn),
    .drawX     (drawX),
    .drawY     (drawY),
    .host_req  (host_req),
    .host_we   (host_we),
    .host_addr (host_addr),
    .host_wdata(host_wdata),
    .host_wstrb(host_wstrb),
    .host_ack  (host_ack),
    .host_rdata(host_rdata),
    .host_err  (host_err),
    .disp_word (disp_word),
`ifdef VRAM_ARB_STATS_EN
    .stall_cnt (stall_cnt),
`endif
    .ram_en    (ram_en),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata)
  );

  always #5 pixel_clk = ~pixel_clk;

  // Read-before-write block RAM with byte enables, plus bench-side fill and poke ports.
  always @(posedge pixel_clk) begin
    if (fill_identity) begin
      for (int i = 0; i < 2048; i++) mem[i] <= 32'(i);
    end else if (poke_en) begin
      mem[poke_addr] <= poke_data;
    end else if (ram_en) begin
      ram_rdata <= mem[ram_addr];
      for (int b = 0; b < 4; b++)
        if (ram_we[b]) mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
    end
  end

  task automatic applyStimulus();
    @(posedge pixel_clk);
    #1;
    if (drawX == 10'd799) begin
      drawX = 10'd0;
      drawY = (drawY == 10'd524) ? 10'd0 : drawY + 10'd1;
    end else begin
      drawX = drawX + 10'd1;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic startReq(input logic we, input logic [10:0] addr, input logic [31:0] data, input logic [3:0] strb);
    host_req   = 1'b1;
    host_we    = we;
    host_addr  = addr;
    host_wdata = data;
    host_wstrb = strb;
  endtask

  // Cycle 0 is the cycle the request was raised in; latency is the cycle index where ack is seen.
  task automatic waitAck(output int lat, output logic [31:0] rd, output logic er, output logic sawEn,
                         output logic c0En, output logic [10:0] c0Addr, output logic [3:0] c0We);
    lat = -1; rd = 32'd0; er = 1'b0; sawEn = 1'b0;
    c0En = 1'b0; c0Addr = 11'd0; c0We = 4'd0;
    for (int k = 0; k < 20; k++) begin
      if (k > 0) applyStimulus();
      @(negedge pixel_clk);
      if (k == 0) begin
        c0En = ram_en; c0Addr = ram_addr; c0We = ram_we;
      end
      if (ram_en) sawEn = 1'b1;
      if (host_ack) begin
        lat = k; rd = host_rdata; er = host_err;
        break;
      end
    end
    host_req = 1'b0;
  endtask

  int          lat;
  logic [31:0] rd;
  logic        er;
  logic        sawEn;
  logic        c0En;
  logic [10:0] c0Addr;
  logic [3:0]  c0We;
  int          ackSeen;

  initial begin
    arstn = 1'b0; fill_identity = 1'b1; poke_en = 1'b0; poke_addr = 11'd0; poke_data = 32'd0;
    drawX = 10'd0; drawY = 10'd500;
    host_req = 1'b0; host_we = 1'b0; host_addr = 11'd0; host_wdata = 32'd0; host_wstrb = 4'd0;
    applyStimulus();
    fill_identity = 1'b0;
    applyStimulus();
    @(negedge pixel_clk);
    checkOutput("rst_ack",   32'(host_ack),   32'd0);
    checkOutput("rst_err",   32'(host_err),   32'd0);
    checkOutput("rst_en",    32'(ram_en),     32'd0);
    checkOutput("rst_we",    32'(ram_we),     32'd0);
    checkOutput("rst_addr",  32'(ram_addr),   32'd0);
    checkOutput("rst_wdata", ram_wdata,       32'd0);
    checkOutput("rst_rdata", host_rdata,      32'd0);
    checkOutput("rst_disp",  disp_word,       32'd0);
    arstn = 1'b1;

    // Display schedule: end of line 15 into line 16, VRAM[i] = i.
    applyStimulus();
    drawY = 10'd15; drawX = 10'd790;
    for (int n = 0; n < 27; n++) begin
      @(negedge pixel_clk);
      if (drawY == 10'd15 && drawX == 10'd797) begin
        checkOutput("row_fetch_en",   32'(ram_en),   32'd1);
        checkOutput("row_fetch_addr", 32'(ram_addr), 32'd40);
      end
      if (drawY == 10'd16 && drawX <= 10'd15)
        checkOutput("disp_l16_col0", disp_word, 32'd40);
      applyStimulus();
    end
    drawY = 10'd31; drawX = 10'd600;
    for (int n = 0; n < 40; n++) begin
      @(negedge pixel_clk);
      if (drawX == 10'd621) begin
        checkOutput("col_fetch_en",   32'(ram_en),   32'd1);
        checkOutput("col_fetch_addr", 32'(ram_addr), 32'd79);
      end
      if (drawX >= 10'd624 && drawX <= 10'd639)
        checkOutput("disp_l31_col39", disp_word, 32'd79);
      applyStimulus();
    end
    drawY = 10'd479; drawX = 10'd795;
    for (int n = 0; n < 4; n++) begin
      @(negedge pixel_clk);
      if (drawX == 10'd797) checkOutput("no_fetch_l479", 32'(ram_en), 32'd0);
      applyStimulus();
    end
    drawY = 10'd524; drawX = 10'd797;
    @(negedge pixel_clk);
    checkOutput("wrap_fetch_en",   32'(ram_en),   32'd1);
    checkOutput("wrap_fetch_addr", 32'(ram_addr), 32'd0);

    // Host write then read back in vertical blanking.
    applyStimulus();
    drawY = 10'd500; drawX = 10'd0;
    startReq(1'b1, 11'd5, 32'hDEADBEEF, 4'hF);
    waitAck(lat, rd, er, sawEn, c0En, c0Addr, c0We);
    checkOutput("wr_lat",   32'(lat), 32'd2);
    checkOutput("wr_err",   32'(er),  32'd0);
    checkOutput("wr_c0_we", 32'(c0We), 32'hF);
    applyStimulus();
    startReq(1'b0, 11'd5, 32'd0, 4'd0);
    waitAck(lat, rd, er, sawEn, c0En, c0Addr, c0We);
    checkOutput("rd_lat",   32'(lat), 32'd3);
    checkOutput("rd_data",  rd,       32'hDEADBEEF);
    checkOutput("rd_err",   32'(er),  32'd0);

    // Partial strobe merge.
    applyStimulus();
    poke_en = 1'b1; poke_addr = 11'd7; poke_data = 32'h11223344;
    applyStimulus();
    poke_en = 1'b0;
    startReq(1'b1, 11'd7, 32'hAABBCCDD, 4'b0101);
    waitAck(lat, rd, er, sawEn, c0En, c0Addr, c0We);
    checkOutput("pwr_lat", 32'(lat), 32'd2);
    applyStimulus();
    startReq(1'b0, 11'd7, 32'd0, 4'd0);
    waitAck(lat, rd, er, sawEn, c0En, c0Addr, c0We);
    checkOutput("prd_data", rd, 32'h11BB33DD);

    // Out-of-range read never touches the RAM.
    applyStimulus();
    startReq(1'b0, 11'd1200, 32'd0, 4'd0);
    waitAck(lat, rd, er, sawEn, c0En, c0Addr, c0We);
    checkOutput("oor_lat",   32'(lat),   32'd2);
    checkOutput("oor_err",   32'(er),    32'd1);
    checkOutput("oor_rdata", rd,         32'd0);
    checkOutput("oor_ram",   32'(sawEn), 32'd0);

    // Collision with the column fetch at drawX=13, drawY=20.
    applyStimulus();
    drawY = 10'd20; drawX = 10'd13;
`ifdef VRAM_ARB_STATS_EN
    stall_before = stall_cnt;
`endif
    startReq(1'b0, 11'd5, 32'd0, 4'd0);
    waitAck(lat, rd, er, sawEn, c0En, c0Addr, c0We);
    checkOutput("col_en",   32'(c0En),   32'd1);
    checkOutput("col_addr", 32'(c0Addr), 32'd41);
    checkOutput("col_we",   32'(c0We),   32'd0);
    checkOutput("col_lat",  32'(lat),    32'd4);
    checkOutput("col_data", rd,          32'hDEADBEEF);
`ifdef VRAM_ARB_STATS_EN
    checkOutput("col_stall", 32'(stall_cnt), 32'(stall_before + 16'd1));
`endif

    // Reset while the read sits in H_RD: dropped with no ack.
    applyStimulus();
    drawY = 10'd500; drawX = 10'd100;
    startReq(1'b0, 11'd5, 32'd0, 4'd0);
    applyStimulus();
    arstn = 1'b0; host_req = 1'b0;
    applyStimulus();
    @(negedge pixel_clk);
    checkOutput("mid_rst_ack",   32'(host_ack), 32'd0);
    checkOutput("mid_rst_en",    32'(ram_en),   32'd0);
    checkOutput("mid_rst_disp",  disp_word,     32'd0);
    checkOutput("mid_rst_rdata", host_rdata,    32'd0);
    applyStimulus();
    arstn = 1'b1;
    ackSeen = 0;
    for (int n = 0; n < 8; n++) begin
      @(negedge pixel_clk);
      if (host_ack) ackSeen++;
      applyStimulus();
    end
    checkOutput("mid_rst_noack", 32'(ackSeen), 32'd0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/vram_port_arbiter.md
Name: vram_port_arbiter

Overview:
- Shares the single-port, 1-cycle-latency VRAM block RAM of the HDMI text controller between the display fetch path and the host (AXI-side) register port.
- Display fetch runs on a fixed schedule derived from drawX/drawY and always wins the RAM port.
- Host reads and writes fill the free slots through a req/ack handshake.
- Sits between the AXI slave logic and the VRAM, in the pixel_clk domain.

Parameters:
H_TOTAL, 800, pixels per line including blanking
V_TOTAL, 525, lines per frame including blanking
H_ACTIVE, 640, visible pixels per line
V_ACTIVE, 480, visible lines
WORDS_PER_ROW, 40, VRAM words per text row (2 glyphs of 8 px per word)
ROW_SHIFT, 4, log2 of scanlines per text row
VRAM_WORDS, 1200, valid VRAM word count
ADDR_W, 11, VRAM word address width

Ports:
pixel_clk  in  1  clock
arstn  in  1  reset, synchronous, active-low
drawX  in  10  current pixel column from VGA timing
drawY  in  10  current line from VGA timing
host_req  in  1  host transaction request, held until host_ack
host_we  in  1  1 = write, 0 = read
host_addr  in  ADDR_W  host word address
host_wdata  in  32  write data
host_wstrb  in  4  byte write enables
host_ack  out  1  one-cycle completion pulse
host_rdata  out  32  read data, valid with host_ack
host_err  out  1  with host_ack: address out of range
disp_word  out  32  VRAM word for the current 16-pixel column
ram_en  out  1  RAM enable
ram_we  out  4  RAM byte write enables
ram_addr  out  ADDR_W  RAM address
ram_wdata  out  32  RAM write data
ram_rdata  in  32  RAM read data, valid the cycle after ram_en

Behaviour:
- Reset (arstn low at a posedge):
  - host_ack, host_err, ram_en and ram_we are 0.
  - host_rdata, disp_word, ram_addr and ram_wdata are 0.
  - Host FSM goes to H_IDLE and the rdata owner tag is cleared.
  - A pending host transaction is dropped with no ack; the requester must re-issue it.
- Fetch slot (combinational decode of drawX/drawY) fires in either case:
  - drawY < V_ACTIVE, drawX[3:0] == 13 and drawX < H_ACTIVE-3. Address = (drawY>>ROW_SHIFT)*WORDS_PER_ROW + ((drawX+3)>>4).
  - drawX == H_TOTAL-3 and nextY < V_ACTIVE, where nextY = drawY+1, wrapping to 0 at V_TOTAL. Address = (nextY>>ROW_SHIFT)*WORDS_PER_ROW.
- Fetch slot cycle: ram_en=1, ram_we=0; the owner tag for the next cycle is DISP.
- Fetch pipeline:
  - The cycle after a fetch slot, ram_rdata is captured into disp_buf.
  - When drawX[3:0] == 15, or drawX == H_TOTAL-1, disp_word <= disp_buf.
  - disp_word is therefore stable for all 16 pixels of its column.
- RAM port driving: ram_en, ram_we, ram_addr and ram_wdata are combinational from the slot decode and host FSM. Fetch has strict priority.
- Host FSM states and transitions:
  - H_IDLE → issue when host_req=1 and no fetch slot this cycle.
    - Out-of-range address (host_addr >= VRAM_WORDS): no RAM access; go to H_ACK with err=1 and rdata=0.
    - Write: ram_en=1, ram_we=host_wstrb, ram_wdata=host_wdata; go to H_ACK.
    - Read: ram_en=1, ram_we=0, owner tag = HOST; go to H_RD.
  - If a fetch slot collides with host_req, the FSM stays in H_IDLE and retries the next cycle.
  - H_RD: capture ram_rdata into the host_rdata register; go to H_ACK. This is legal even if this cycle is a fetch slot; the owner tag keeps the data paths separate.
  - H_ACK: host_ack=1 for exactly one cycle, with host_err per the issue decision; go to H_IDLE.
- Host request rules:
  - A host_req still high after ack is treated as a new transaction, sampled from H_IDLE the next cycle.
  - Inputs are sampled only at issue and may change after it.
- Latency, no collision: write ack 2 cycles after issue; read ack 3 cycles. A collision adds 1 cycle; at most one collision is possible per transaction.
- Partial writes: bytes with a 0 strobe bit are untouched in RAM. The host_rdata of the following read reflects the merge.

Optional Feature:
- VRAM_ARB_STATS_EN defined:
  - Adds output stall_cnt [15:0], a saturating count of cycles where host_req=1 in H_IDLE and a fetch slot blocked issue.
  - Cleared on reset and whenever drawX==0 and drawY==0.
- Undefined: port and counter absent; the rest of the behaviour is identical.

Test Plan:
- Reset mid-read: assert arstn=0 during H_RD → next cycle host_ack=0, ram_en=0 and disp_word=0; no ack ever follows for that request.
- Write, then read back with the host request held during blanking (drawY=500): write addr 5, data 0xDEADBEEF, wstrb F → ack 2 cycles after req. Read addr 5 → ack at 3 cycles, rdata 0xDEADBEEF, err=0.
- Partial strobe: preload 0x11223344, write 0xAABBCCDD with wstrb 4'b0101 → readback 0x11BB33DD.
- Collision: host_req rises at drawX=13, drawY=20 → ram_addr=41 (row 1, col 1) with we=0 that cycle; host issued at drawX=14; read ack 4 cycles after req.
- Display schedule: VRAM[i]=i, run a full frame → disp_word=40 throughout drawX 0..15 of line 16, =79 throughout drawX 624..639 of line 31. No fetch at drawX=797 of line 479.
- Out of range: read addr 1200 → ack with err=1, rdata=0, ram_en never asserted. With VRAM_ARB_STATS_EN, the collision case increments stall_cnt by exactly 1.
